// File: rtl/sram_controller_pkg.sv
// Shared constants and types for the multi-line pixel buffer.
// Defaults match a 1920x1080, 12-bit RAW stream with a 5-row window.
package sram_controller_pkg;

   localparam int NUM        = 5;
   localparam int DATADEPTH  = 12;
   localparam int IMG_WIDTH  = 1920;
   localparam int IMG_HEIGHT = 1080;

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT + 1);

   typedef logic [DATADEPTH-1:0] pixel_t;

endpackage

// File: rtl/line_buffer_ram.sv
// One image line of storage: single port, read-before-write.
// The read is combinational so a cascade write sees the old word.
module line_buffer_ram
   import sram_controller_pkg::*;
#(
   parameter int DEPTH = IMG_WIDTH,
   parameter int WIDTH = DATADEPTH,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // Store the new word at the end of the accepted cycle
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sram_controller.sv
// Multi-line pixel buffer producing a NUM-row vertical column per pixel.
// SRAM_CTRL_EDGE_REPLICATE_EN: replicate row 0 upward and enable from row 0.
module sram_controller #(
   parameter int NUM        = sram_controller_pkg::NUM,
   parameter int DATADEPTH  = sram_controller_pkg::DATADEPTH,
   parameter int IMG_WIDTH  = sram_controller_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT = sram_controller_pkg::IMG_HEIGHT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vsync,
   input  logic                     hsync,
   input  logic [DATADEPTH-1:0]     data_i,
   output logic [NUM*DATADEPTH-1:0] data_o,
   output logic [DATADEPTH-1:0]     data_o_bypass,
   output logic                     en_o
);

   import sram_controller_pkg::*;

   localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int RW = $clog2(IMG_HEIGHT + 1);

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_END   = RW'(IMG_HEIGHT);
   localparam logic [RW-1:0] ROW_FIRST = RW'(NUM - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic acc;
   logic active;
   logic fire;

   logic [(NUM-1)*DATADEPTH-1:0] rd;
   logic [DATADEPTH-1:0]         tap [NUM];
   logic [DATADEPTH-1:0]         sel [NUM];
   logic [NUM*DATADEPTH-1:0]     col_word;

   assign acc    = vsync & hsync;
   assign active = acc & (row < ROW_END);

`ifdef SRAM_CTRL_EDGE_REPLICATE_EN
   assign fire = active;
`else
   assign fire = active & (row >= ROW_FIRST);
`endif

   // Tap 0 is the live pixel, tap k is the same column k rows up
   always_comb begin
      tap[0] = data_i;
      for (int k = 1; k < NUM; k++) begin
         tap[k] = rd[(k-1)*DATADEPTH +: DATADEPTH];
      end
   end

   generate
      for (genvar k = 0; k < NUM - 1; k++) begin : g_line
         line_buffer_ram #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (DATADEPTH),
            .AW    (CW)
         ) u_ram (
            .clk   (clk),
            .en    (active),
            .addr  (col),
            .wdata (tap[k]),
            .rdata (rd[k*DATADEPTH +: DATADEPTH])
         );
      end
   endgenerate

`ifdef SRAM_CTRL_EDGE_REPLICATE_EN
   logic [DATADEPTH-1:0] top;

   // Rows above the frame top reuse the row-0 pixel, found at tap[row]
   always_comb begin
      top = tap[0];
      for (int j = 1; j < NUM; j++) begin
         if (row == RW'(j)) begin
            top = tap[j];
         end
      end
      for (int k = 0; k < NUM; k++) begin
         sel[k] = (RW'(k) > row) ? top : tap[k];
      end
   end
`else
   // Without replication every slice comes straight from its tap
   always_comb begin
      for (int k = 0; k < NUM; k++) begin
         sel[k] = tap[k];
      end
   end
`endif

   // Pack the slices, slice 0 in the low bits
   always_comb begin
      col_word = '0;
      for (int k = 0; k < NUM; k++) begin
         col_word[k*DATADEPTH +: DATADEPTH] = sel[k];
      end
   end

   // Raster position; vsync low restarts, row saturates at frame end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (!vsync) begin
         col <= '0;
         row <= '0;
      end else if (active) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Registered column, bypass pixel and strobe; data held when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_o          <= 1'b0;
         data_o        <= '0;
         data_o_bypass <= '0;
      end else if (!vsync) begin
         en_o <= 1'b0;
      end else begin
         en_o <= fire;
         if (fire) begin
            data_o        <= col_word;
            data_o_bypass <= data_i;
         end
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed raster fill then random stream,
// checked against a frame-array model of the vertical window.
module tb_sram_controller;

   localparam int NUM = 5;
   localparam int DD  = 12;
   localparam int W   = 40;
   localparam int H   = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              vsync;
   logic              hsync;
   logic [DD-1:0]     data_i;
   logic [NUM*DD-1:0] data_o;
   logic [DD-1:0]     data_o_bypass;
   logic              en_o;

   always #5 clk = ~clk;

   sram_controller #(
      .NUM        (NUM),
      .DATADEPTH  (DD),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .vsync         (vsync),
      .hsync         (hsync),
      .data_i        (data_i),
      .data_o        (data_o),
      .data_o_bypass (data_o_bypass),
      .en_o          (en_o)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int pulses = 0;

   int mrow;
   int mcol;
   int img [H][W];

   logic              want_en;
   logic [NUM*DD-1:0] want_do;
   logic [DD-1:0]     want_byp;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] want);
      n_chk++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic h,
                       input logic [DD-1:0] d);
      logic fire;
      @(negedge clk);
      rst_n  = r;
      vsync  = v;
      hsync  = h;
      data_i = d;
      if (!r) begin
         mrow     = 0;
         mcol     = 0;
         want_en  = 1'b0;
         want_do  = '0;
         want_byp = '0;
      end else if (!v) begin
         mrow    = 0;
         mcol    = 0;
         want_en = 1'b0;
      end else if (h && mrow < H) begin
         img[mrow][mcol] = int'(d);
`ifdef SRAM_CTRL_EDGE_REPLICATE_EN
         fire = 1'b1;
`else
         fire = (mrow >= NUM - 1);
`endif
         want_en = fire;
         if (fire) begin
            for (int k = 0; k < NUM; k++) begin
               int r0;
               r0 = mrow - k;
               if (r0 < 0) r0 = 0;
               want_do[k*DD +: DD] = DD'(img[r0][mcol]);
            end
            want_byp = d;
         end
         mcol++;
         if (mcol == W) begin
            mcol = 0;
            mrow++;
         end
      end else begin
         want_en = 1'b0;
      end
      @(posedge clk);
      #1;
      check("en_o", 64'(en_o), 64'(want_en));
      check("data_o", 64'(data_o), 64'(want_do));
      check("bypass", 64'(data_o_bypass), 64'(want_byp));
      if (en_o) pulses++;
   endtask

   initial begin
      logic [NUM*DD-1:0] first_col;
      logic [DD-1:0]     stall_px;
      int                n_expect;
      first_col = 60'h000_010_020_030_040;
      stall_px  = 12'h04A;
      rst_n  = 1'b0;
      vsync  = 1'b1;
      hsync  = 1'b1;
      data_i = '0;
      mrow   = 0;
      mcol   = 0;

      repeat (5) step(1'b0, 1'b1, 1'b1, DD'($urandom));
      pulses = 0;

      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r == 5 && c == 10) begin
               repeat (3) step(1'b1, 1'b1, 1'b0, 12'hFFF);
            end
            step(1'b1, 1'b1, 1'b1, DD'(r * 16 + c));
            if (r == 4 && c == 0) begin
               check("first_col", 64'(data_o), 64'(first_col));
               check("first_en", 64'(en_o), 64'd1);
            end
            if (r == 5 && c == 10) begin
               check("stall_slice1", 64'(data_o[2*DD-1:DD]), 64'(stall_px));
            end
`ifdef SRAM_CTRL_EDGE_REPLICATE_EN
            if (r == 1 && c == 3) begin
               check("edge_rep", 64'(data_o), 64'h003_003_003_003_013);
            end
`endif
         end
      end

      repeat (20) step(1'b1, 1'b1, 1'b1, DD'($urandom));

`ifdef SRAM_CTRL_EDGE_REPLICATE_EN
      n_expect = H * W;
`else
      n_expect = (H - (NUM - 1)) * W;
`endif
      check("pulses", 64'(pulses), 64'(n_expect));

      repeat (10) step(1'b1, 1'b0, 1'b1, DD'($urandom));

      for (int i = 0; i < 6000; i++) begin
         logic v;
         logic h;
         v = ($urandom_range(0, 999) != 0);
         h = ($urandom_range(0, 3) != 0);
         if (i == 2500) begin
            repeat (2) step(1'b0, 1'b1, 1'b1, DD'($urandom));
         end
         step(1'b1, v, h, DD'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
